// File: rtl/instruction_loader_pkg.sv
// Shared definitions for the instruction loader: opcode set, legality check,
// FSM state encoding and error-cause encoding.
package instruction_loader_pkg;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] PPU    = 7'b0101000;
  localparam logic [6:0] SAC    = 7'b0101001;
  localparam logic [6:0] RND    = 7'b0101010;
  localparam logic [6:0] UAD    = 7'b0101011;
  localparam logic [6:0] RTI    = 7'b0001000;
  localparam logic [6:0] RSI    = 7'b0001001;
  localparam logic [6:0] RDI    = 7'b0001010;
  localparam logic [6:0] SND    = 7'b0001011;

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_CHK, S_DONE, S_ERR
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE   = 2'd0,
    ERR_LEN    = 2'd1,
    ERR_OPCODE = 2'd2,
    ERR_CHK    = 2'd3
  } err_t;

  function automatic logic opcode_legal(input logic [6:0] op);
    case (op)
      OP_IMM, OP, AUIPC, LUI, LOAD, STORE, JAL, JALR, BRANCH,
      PPU, SAC, RND, UAD, RTI, RSI, RDI, SND: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/instruction_loader_word_packer.sv
// Assembles little-endian bytes into 32-bit words and keeps the frame's running XOR.
// word is combinational: the three stored bytes plus the byte currently presented.
module instr_word_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  rx_byte,
  output logic [31:0] word,
  output logic        word_last,
  output logic [7:0]  run_xor
);

  logic [23:0] low_q;
  logic [1:0]  byte_cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      low_q    <= '0;
      byte_cnt <= '0;
      run_xor  <= '0;
    end else if (byte_en) begin
      case (byte_cnt)
        2'd0:    low_q[7:0]   <= rx_byte;
        2'd1:    low_q[15:8]  <= rx_byte;
        2'd2:    low_q[23:16] <= rx_byte;
        default: ;
      endcase
      byte_cnt <= byte_cnt + 2'd1;
      run_xor  <= run_xor ^ rx_byte;
    end
  end

  assign word      = {rx_byte, low_q};
  assign word_last = byte_en && (byte_cnt == 2'd3);

endmodule

// File: rtl/instruction_loader.sv
// Receives a framed program image over a byte link, writes it to instruction
// memory word by word, verifies the checksum and releases the CPU on success.
module instruction_loader
  import instruction_loader_pkg::*;
#(
  parameter int          ADDR_W    = 12,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_byte,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic              reload,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err,
  output logic [1:0]        err_code
);

  localparam logic [31:0] MAX_WORDS = 32'd1 << ADDR_W;

  state_t      state;
  err_t        err_q;
  logic [7:0]  len_lo;
  logic [15:0] len;
  logic        accept;
  logic        data_en;
  logic        len_hi_acc;
  logic [31:0] word;
  logic        word_last;
  logic [7:0]  run_xor;

  assign accept     = rx_valid && rx_ready;
  assign data_en    = accept && (state == S_DATA);
  assign len_hi_acc = accept && (state == S_LEN_HI);
  assign err_code   = err_q;

  // The link is stalled for the single cycle a word is being written.
  assign rx_ready = (state inside {S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_CHK}) && !imem_we;

  instr_word_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .clear     (len_hi_acc),
    .byte_en   (data_en),
    .rx_byte   (rx_byte),
    .word      (word),
    .word_last (word_last),
    .run_xor   (run_xor)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_hold   <= 1'b1;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
      err_q      <= ERR_NONE;
      len_lo     <= '0;
      len        <= '0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept && rx_byte == SYNC_BYTE) state <= S_LEN_LO;
        end
        S_LEN_LO: begin
          if (accept) begin
            len_lo <= rx_byte;
            state  <= S_LEN_HI;
          end
        end
        S_LEN_HI: begin
          if (accept) begin
            len       <= {rx_byte, len_lo};
            imem_addr <= '0;
            if ({16'd0, rx_byte, len_lo} > MAX_WORDS) begin
              state    <= S_ERR;
              load_err <= 1'b1;
              err_q    <= ERR_LEN;
            end else if ({rx_byte, len_lo} == 16'd0) begin
              state <= S_CHK;
            end else begin
              state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (imem_we) begin
            imem_addr <= imem_addr + ADDR_W'(1);
            if (32'(imem_addr) == 32'(len) - 32'd1) state <= S_CHK;
          end else if (word_last) begin
            if (opcode_legal(word[6:0])) begin
              imem_we    <= 1'b1;
              imem_wdata <= word;
            end else begin
              state    <= S_ERR;
              load_err <= 1'b1;
              err_q    <= ERR_OPCODE;
            end
          end
        end
        S_CHK: begin
          if (accept) begin
            if (rx_byte == run_xor) begin
              state     <= S_DONE;
              load_done <= 1'b1;
              cpu_hold  <= 1'b0;
            end else begin
              state    <= S_ERR;
              load_err <= 1'b1;
              err_q    <= ERR_CHK;
            end
          end
        end
        S_DONE: begin
          if (reload) begin
            state     <= S_IDLE;
            load_done <= 1'b0;
            cpu_hold  <= 1'b1;
          end
        end
        S_ERR: begin
          if (reload) begin
            state    <= S_IDLE;
            load_err <= 1'b0;
            err_q    <= ERR_NONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_loader.sv
// Directed bench for instruction_loader: frame table plus reset and length corner cases.
module tb_instruction_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_byte = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_valid4 = 1'b0;
  logic        reload = 1'b0;
  logic        reload4 = 1'b0;

  logic        rx_ready, imem_we, cpu_hold, load_done, load_err;
  logic [11:0] imem_addr;
  logic [31:0] imem_wdata;
  logic [1:0]  err_code;

  logic        rx_ready4, imem_we4, cpu_hold4, load_done4, load_err4;
  logic [3:0]  imem_addr4;
  logic [31:0] imem_wdata4;
  logic [1:0]  err_code4;

  int checks = 0;
  int errors = 0;

  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  int          we4_cnt = 0;

  always #5 clk = ~clk;

  instruction_loader #(.ADDR_W(12), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .rst(rst), .rx_byte(rx_byte), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .reload(reload), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_hold(cpu_hold), .load_done(load_done), .load_err(load_err), .err_code(err_code)
  );

  instruction_loader #(.ADDR_W(4), .SYNC_BYTE(8'hA5)) dut4 (
    .clk(clk), .rst(rst), .rx_byte(rx_byte), .rx_valid(rx_valid4), .rx_ready(rx_ready4),
    .reload(reload4), .imem_we(imem_we4), .imem_addr(imem_addr4), .imem_wdata(imem_wdata4),
    .cpu_hold(cpu_hold4), .load_done(load_done4), .load_err(load_err4), .err_code(err_code4)
  );

  always @(negedge clk) begin
    if (imem_we) begin
      wr_addr.push_back(32'(imem_addr));
      wr_data.push_back(imem_wdata);
    end
    if (imem_we4) we4_cnt <= we4_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input int target, input logic [7:0] b);
    int waited;
    waited = 0;
    @(negedge clk);
    while ((target == 0 ? rx_ready : rx_ready4) !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 50) begin
      checks++;
      errors++;
      $display("FAIL rx_ready_timeout: got 0 expected 1 (byte %0h)", b);
    end else begin
      rx_byte = b;
      if (target == 0) rx_valid = 1'b1; else rx_valid4 = 1'b1;
      @(negedge clk);
      rx_valid  = 1'b0;
      rx_valid4 = 1'b0;
    end
  endtask

  typedef struct {
    string       name;
    int          nb;
    logic [7:0]  b [16];
    int          nwr;
    logic [31:0] w [2];
    logic        done;
    logic        err;
    logic [1:0]  code;
  } vec_t;

  vec_t tbl [5];

  initial begin
    tbl[0].name = "good";
    tbl[0].nb = 12;
    tbl[0].b  = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93,
                  8'h00, 8'h10, 8'h00, 8'h90, 8'h00, 8'h00, 8'h00, 8'h00};
    tbl[0].nwr = 2; tbl[0].w = '{32'h00000013, 32'h00100093};
    tbl[0].done = 1'b1; tbl[0].err = 1'b0; tbl[0].code = 2'd0;

    tbl[1].name = "badchk";
    tbl[1].nb = 12;
    tbl[1].b  = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93,
                  8'h00, 8'h10, 8'h00, 8'h91, 8'h00, 8'h00, 8'h00, 8'h00};
    tbl[1].nwr = 2; tbl[1].w = '{32'h00000013, 32'h00100093};
    tbl[1].done = 1'b0; tbl[1].err = 1'b1; tbl[1].code = 2'd3;

    tbl[2].name = "illop";
    tbl[2].nb = 7;
    tbl[2].b  = '{8'hA5, 8'h01, 8'h00, 8'h7F, 8'h00, 8'h00, 8'h00, 8'h00,
                  8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    tbl[2].nwr = 0; tbl[2].w = '{32'h0, 32'h0};
    tbl[2].done = 1'b0; tbl[2].err = 1'b1; tbl[2].code = 2'd2;

    tbl[3].name = "junk_len0";
    tbl[3].nb = 6;
    tbl[3].b  = '{8'h00, 8'h33, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                  8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    tbl[3].nwr = 0; tbl[3].w = '{32'h0, 32'h0};
    tbl[3].done = 1'b1; tbl[3].err = 1'b0; tbl[3].code = 2'd0;

    // 0xA5 inside the payload is plain data; second word uses the custom PPU opcode.
    tbl[4].name = "sync_in_data";
    tbl[4].nb = 12;
    tbl[4].b  = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'hA5, 8'hA5, 8'hA5, 8'h28,
                  8'h00, 8'h00, 8'h00, 8'h9E, 8'h00, 8'h00, 8'h00, 8'h00};
    tbl[4].nwr = 2; tbl[4].w = '{32'hA5A5A513, 32'h00000028};
    tbl[4].done = 1'b1; tbl[4].err = 1'b0; tbl[4].code = 2'd0;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_we",    32'(imem_we),   32'd0);
    check("rst_addr",  32'(imem_addr), 32'd0);
    check("rst_wdata", imem_wdata,     32'd0);
    check("rst_hold",  32'(cpu_hold),  32'd1);
    check("rst_done",  32'(load_done), 32'd0);
    check("rst_err",   32'(load_err),  32'd0);
    check("rst_code",  32'(err_code),  32'd0);
    check("rst_ready", 32'(rx_ready),  32'd1);

    for (int f = 0; f < 5; f++) begin
      wr_addr.delete();
      wr_data.delete();
      for (int i = 0; i < tbl[f].nb; i++) send_byte(0, tbl[f].b[i]);
      repeat (3) @(negedge clk);
      check({tbl[f].name, "_nwr"}, 32'(wr_addr.size()), 32'(tbl[f].nwr));
      for (int k = 0; k < tbl[f].nwr; k++) begin
        check({tbl[f].name, "_addr"}, (k < wr_addr.size()) ? wr_addr[k] : 32'hDEADBEEF, 32'(k));
        check({tbl[f].name, "_data"}, (k < wr_data.size()) ? wr_data[k] : 32'hDEADBEEF, tbl[f].w[k]);
      end
      check({tbl[f].name, "_done"},  32'(load_done), 32'(tbl[f].done));
      check({tbl[f].name, "_err"},   32'(load_err),  32'(tbl[f].err));
      check({tbl[f].name, "_code"},  32'(err_code),  32'(tbl[f].code));
      check({tbl[f].name, "_hold"},  32'(cpu_hold),  32'(!tbl[f].done));
      check({tbl[f].name, "_ready"}, 32'(rx_ready),  32'd0);
      @(negedge clk); reload = 1'b1;
      @(negedge clk); reload = 1'b0;
      check({tbl[f].name, "_rl_hold"},  32'(cpu_hold),  32'd1);
      check({tbl[f].name, "_rl_done"},  32'(load_done), 32'd0);
      check({tbl[f].name, "_rl_err"},   32'(load_err),  32'd0);
      check({tbl[f].name, "_rl_code"},  32'(err_code),  32'd0);
      check({tbl[f].name, "_rl_ready"}, 32'(rx_ready),  32'd1);
    end

    // Reload outside DONE/ERR must be ignored: pulse it mid-frame, frame still completes.
    wr_addr.delete();
    wr_data.delete();
    for (int i = 0; i < 5; i++) send_byte(0, tbl[0].b[i]);
    @(negedge clk); reload = 1'b1;
    @(negedge clk); reload = 1'b0;
    for (int i = 5; i < 12; i++) send_byte(0, tbl[0].b[i]);
    repeat (3) @(negedge clk);
    check("midreload_nwr",  32'(wr_addr.size()), 32'd2);
    check("midreload_done", 32'(load_done), 32'd1);
    @(negedge clk); reload = 1'b1;
    @(negedge clk); reload = 1'b0;

    // Reset after five payload bytes: word 0 lands, then the frame is abandoned.
    for (int i = 0; i < 8; i++) send_byte(0, tbl[0].b[i]);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("midrst_hold",  32'(cpu_hold),  32'd1);
    check("midrst_addr",  32'(imem_addr), 32'd0);
    check("midrst_ready", 32'(rx_ready),  32'd1);
    wr_addr.delete();
    wr_data.delete();
    for (int i = 0; i < 12; i++) send_byte(0, tbl[0].b[i]);
    repeat (3) @(negedge clk);
    check("midrst_nwr",   32'(wr_addr.size()), 32'd2);
    check("midrst_a0",    (wr_addr.size() > 0) ? wr_addr[0] : 32'hDEADBEEF, 32'd0);
    check("midrst_d0",    (wr_data.size() > 0) ? wr_data[0] : 32'hDEADBEEF, 32'h00000013);
    check("midrst_a1",    (wr_addr.size() > 1) ? wr_addr[1] : 32'hDEADBEEF, 32'd1);
    check("midrst_d1",    (wr_data.size() > 1) ? wr_data[1] : 32'hDEADBEEF, 32'h00100093);
    check("midrst_done",  32'(load_done), 32'd1);
    check("midrst_hold2", 32'(cpu_hold),  32'd0);

    // ADDR_W=4: N=16 is the largest legal length, N=17 is rejected.
    send_byte(1, 8'hA5); send_byte(1, 8'h10); send_byte(1, 8'h00);
    check("len16_err",   32'(load_err4),   32'd0);
    check("len16_ready", 32'(rx_ready4),   32'd1);
    check("len16_addr",  32'(imem_addr4),  32'd0);
    check("len16_wdata", imem_wdata4,      32'd0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    send_byte(1, 8'hA5); send_byte(1, 8'h11); send_byte(1, 8'h00);
    check("len17_err",   32'(load_err4),  32'd1);
    check("len17_code",  32'(err_code4),  32'd1);
    check("len17_ready", 32'(rx_ready4),  32'd0);
    repeat (3) @(negedge clk);
    check("len17_we",    32'(we4_cnt),    32'd0);
    check("len17_code2", 32'(err_code4),  32'd1);
    check("len17_hold",  32'(cpu_hold4),  32'd1);
    check("len17_done",  32'(load_done4), 32'd0);
    @(negedge clk); reload4 = 1'b1;
    @(negedge clk); reload4 = 1'b0;
    check("len17_rl_code", 32'(err_code4), 32'd0);
    check("len17_rl_err",  32'(load_err4), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
